// File: rtl/bcd_keypad_ctrl.sv
// bcd_keypad_ctrl: debounced 10-key decimal keypad scanner with valid/ready digit port and BCD shift buffer.
// Optional KEYPAD_MULTI_REJECT_EN drops multi-key presses and pulses reject instead of emitting.
module bcd_keypad_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int NDIGITS = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [9:0]                     keys,
    input  logic                           clear,
    output logic [3:0]                     digit,
    output logic                           digit_valid,
    input  logic                           digit_ready,
    output logic                           multi_key,
    output logic [4*NDIGITS-1:0]           digits,
    output logic [$clog2(NDIGITS+1)-1:0]   count,
    output logic                           full,
    output logic                           overflow
`ifdef KEYPAD_MULTI_REJECT_EN
    ,
    output logic                           reject
`endif
);
    localparam int CNTW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CW = $clog2(NDIGITS + 1);
    localparam logic [CNTW-1:0] DC = CNTW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] NMAX = CW'(NDIGITS);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, EMIT, RELEASE} state_t;

    state_t state, state_n;
    logic [CNTW-1:0] cnt, cnt_n, cnt_inc;
    logic [9:0] snap, snap_n, src;
    logic [3:0] enc, digit_n;
    logic dv_n, mk_n, multi, go, hs, rej_n;
    logic [4*NDIGITS+3:0] sh;

    assign hs = digit_valid & digit_ready;
    assign full = count == NMAX;
    assign cnt_inc = cnt + 1'b1;
    assign sh = {digits, digit};

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        snap_n = snap;
        dv_n = digit_valid;
        digit_n = digit;
        mk_n = multi_key;
        rej_n = 1'b0;
        go = 1'b0;
        // DEBOUNCE_CYCLES==1 decides straight from IDLE, before snap is loaded
        src = state == IDLE ? keys : snap;
        multi = |(src & (src - 10'd1));
        enc = 4'd0;
        for (int i = 9; i >= 0; i--)
            if (src[i]) enc = 4'(i);
        case (state)
            IDLE:
                if (enable && keys != 10'd0) begin
                    snap_n = keys;
                    cnt_n = CNTW'(1);
                    if (DEBOUNCE_CYCLES == 1) go = 1'b1;
                    else state_n = DEBOUNCE;
                end
            DEBOUNCE:
                if (keys == snap) begin
                    cnt_n = cnt_inc;
                    go = cnt_inc == DC;
                end else begin
                    state_n = IDLE;
                    cnt_n = '0;
                end
            EMIT:
                if (hs) begin
                    dv_n = 1'b0;
                    cnt_n = '0;
                    state_n = RELEASE;
                end
            default:
                if (keys == 10'd0) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == DC) begin
                        state_n = IDLE;
                        cnt_n = '0;
                    end
                end else cnt_n = '0;
        endcase
        if (go) begin
`ifdef KEYPAD_MULTI_REJECT_EN
            if (multi) begin
                state_n = RELEASE;
                cnt_n = '0;
                rej_n = 1'b1;
            end else
`endif
            begin
                state_n = EMIT;
                dv_n = 1'b1;
                digit_n = enc;
                mk_n = multi;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            snap <= '0;
            digit <= '0;
            digit_valid <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            snap <= snap_n;
            digit <= digit_n;
            digit_valid <= dv_n;
            multi_key <= mk_n;
        end
    end

`ifdef KEYPAD_MULTI_REJECT_EN
    always_ff @(posedge clk) begin
        if (rst) reject <= 1'b0;
        else reject <= rej_n;
    end
`endif

    // clear beats a same-cycle handshake: the digit is consumed but not stored
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            digits <= '0;
            count <= '0;
            overflow <= 1'b0;
        end else if (hs) begin
            digits <= sh[4*NDIGITS-1:0];
            if (count < NMAX) count <= count + 1'b1;
            else overflow <= 1'b1;
        end
    end
endmodule

// File: doc/bcd_keypad_ctrl.md
Name: bcd_keypad_ctrl

Overview:
- Scan controller for a 10-key decimal keypad with one active-high line per key (key n = digit n).
- Debounces each press and priority-encodes it to a BCD digit; lowest index wins, same rule as the team's BCD encoder.
- Hands each digit out on a valid/ready port and accumulates digits in an NDIGITS-deep shift buffer for display/entry logic.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive identical samples needed to accept a press or a release; must be >= 1
NDIGITS, 4, depth of the digit buffer in BCD nibbles; must be >= 1

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
enable  input  1  allows detection of new presses; does not abort one in progress
keys  input  10  raw key lines, bit n = key n, active high
clear  input  1  synchronous clear of buffer, count and overflow
digit  output  4  BCD code of the pending press (0000..1001)
digit_valid  output  1  pending digit available
digit_ready  input  1  consumer accepts digit when high with digit_valid
multi_key  output  1  pending press had more than one key set (qualified by digit_valid)
digits  output  4*NDIGITS  buffer; nibble 0 = newest digit
count  output  clog2(NDIGITS+1)  digits held, saturates at NDIGITS
full  output  1  count == NDIGITS
overflow  output  1  sticky; an accepted digit pushed out an old one

Behaviour:
- Reset (rst=1 at edge): state IDLE, snapshot=0, debounce counter=0.
  - digit=0000, digit_valid=0, multi_key=0, digits=0, count=0, full=0, overflow=0.
  - rst has priority over every other input.
- All outputs are registered.
- FSM states: IDLE, DEBOUNCE, EMIT, RELEASE.
- IDLE:
  - enable=1 and keys!=0 at an edge: snapshot<=keys, cnt<=1.
  - Goes to EMIT if DEBOUNCE_CYCLES==1, otherwise DEBOUNCE.
  - enable=0 or keys==0: stay.
- DEBOUNCE:
  - keys==snapshot: cnt++. When cnt reaches DEBOUNCE_CYCLES, go to EMIT.
  - keys!=snapshot (bounce, key change or release): return to IDLE, cnt<=0. No digit is produced.
- EMIT:
  - digit_valid=1; digit = index of lowest set bit in snapshot; multi_key=1 if popcount(snapshot)>1.
  - digit, multi_key and digit_valid are stable until the handshake completes. keys are ignored in this state.
  - Handshake is digit_valid & digit_ready at an edge. On handshake: digit_valid<=0, cnt<=0, go to RELEASE.
  - Buffer update on handshake: digits <= {digits[4*NDIGITS-5:0], digit}.
  - If count<NDIGITS: count++. Otherwise count holds and overflow<=1.
- RELEASE:
  - keys==0: cnt++. When cnt reaches DEBOUNCE_CYCLES, go to IDLE.
  - keys!=0: cnt<=0, stay.
  - A key held down never re-emits; there is no autorepeat.
- Latency: with keys stable from edge E0, digit_valid is high after edge E(DEBOUNCE_CYCLES-1).
- clear:
  - Forces digits=0, count=0, overflow=0 at the edge.
  - Does not affect the FSM or the handshake.
  - clear in the same cycle as a handshake: clear wins. The digit is consumed but not stored; count=0.
- enable deasserted mid-press: the sequence completes through RELEASE.
- full is a combinational compare of the registered count.

Optional Feature:
- Macro: KEYPAD_MULTI_REJECT_EN.
- Defined:
  - A debounced press with popcount(snapshot)>1 does not enter EMIT. The FSM goes to RELEASE and pulses output reject high for one cycle.
  - The buffer and count are untouched.
  - multi_key is then always 0 whenever digit_valid=1.
- Not defined:
  - The reject port is absent.
  - Multi-key presses emit the lowest index with multi_key=1.

Test Plan (DEBOUNCE_CYCLES=4, NDIGITS=4):
- keys=0x008 held 4 cycles, digit_ready=1 -> digit_valid high after 4th edge, digit=0011, multi_key=0. After handshake: digits=0x0003, count=1.
- keys toggling 0x020/0x000 every 2 cycles for 20 cycles -> digit_valid never asserts, count=0.
- Press 1,2,3,4,5 with full release between, ready=1 -> digits=0x2345, count=4, full=1, overflow=1. Then clear=1 -> digits=0, count=0, overflow=0.
- keys=0x201 stable, ready=0 for 10 cycles -> digit_valid held, digit=0000, multi_key=1. Raise ready -> single handshake. With KEYPAD_MULTI_REJECT_EN: one reject pulse, no valid, count unchanged.
- Key 7 held 50 cycles, ready=1 -> exactly one handshake. Release 3 cycles, re-press 2 cycles, release 4 cycles -> still one digit total.
- rst=1 while in EMIT with digit_valid=1 -> next cycle digit_valid=0, digits=0, count=0, FSM in IDLE. enable=0 with keys=0x002 -> no detection.
